// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback stage around an external 32-bit combinational ALU.
// Accepts one instruction over valid/ready, reads two sources from a
// synchronous-read register file, drives the ALU, captures the result and flags,
// then writes the result back. Owns the architectural C/Z/N flag register.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (adds illegal_op, suppresses
// write and flag update for op codes outside the supported set).
//
// state | meaning
// IDLE  | waiting for an instruction
// READ  | RF read addresses presented, data returns next cycle
// EXEC  | ALU driven from RF data, result/flags captured at end of cycle
// WB    | result written back; a new instruction may be accepted here
module alu_sequencer #(
  parameter int          RA_W    = 4,
  parameter logic [7:0]  NOWB_OP = 8'd8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      req_op,
  input  logic [RA_W-1:0] req_rd,
  input  logic [RA_W-1:0] req_ra,
  input  logic [RA_W-1:0] req_rb,
  input  logic            req_imm_en,
  input  logic [31:0]     req_imm,
  input  logic            req_setflags,
  output logic [RA_W-1:0] rf_raddr_a,
  output logic [RA_W-1:0] rf_raddr_b,
  input  logic [31:0]     rf_rdata_a,
  input  logic [31:0]     rf_rdata_b,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [7:0]      alu_op,
  output logic            alu_carry_in,
  input  logic [31:0]     alu_c,
  input  logic            alu_carry_out,
  input  logic            alu_is_zero,
  input  logic            alu_is_negative,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_n,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  output logic            illegal_op,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t          state_q, state_d;
  logic [7:0]      op_q;
  logic [RA_W-1:0] rd_q, ra_q, rb_q;
  logic            imm_en_q, setflags_q;
  logic [31:0]     imm_q;
  logic [31:0]     wdata_q;
  logic [31:0]     alu_a_q, alu_b_q;
  logic [2:0]      flags_q;
  logic            accept;
  logic            illegal_w;

  assign req_ready = (state_q == S_IDLE) || (state_q == S_WB);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal_w  = !((op_q <= 8'd8) || (op_q == 8'd12) || (op_q == 8'd13) || (op_q == 8'd16));
  assign illegal_op = (state_q == S_WB) && illegal_w;
`else
  assign illegal_w  = 1'b0;
`endif

  // Next-state logic for the issue/writeback sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = accept ? S_READ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch all request fields on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      setflags_q <= 1'b0;
    end else if (accept) begin
      op_q       <= req_op;
      rd_q       <= req_rd;
      ra_q       <= req_ra;
      rb_q       <= req_rb;
      imm_en_q   <= req_imm_en;
      imm_q      <= req_imm;
      setflags_q <= req_setflags;
    end
  end

  // End of EXEC: capture result, hold operands, update flags when requested
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      flags_q <= '0;
    end else if (state_q == S_EXEC) begin
      wdata_q <= alu_c;
      alu_a_q <= alu_a;
      alu_b_q <= alu_b;
      if (setflags_q && !illegal_w)
        flags_q <= {alu_carry_out, alu_is_zero, alu_is_negative};
    end
  end

  // Addresses come straight from the latched fields so they stay stable READ..EXEC
  assign rf_raddr_a = ra_q;
  assign rf_raddr_b = rb_q;

  // Operands are live from RF data in EXEC and frozen elsewhere
  assign alu_a        = (state_q == S_EXEC) ? rf_rdata_a : alu_a_q;
  assign alu_b        = (state_q == S_EXEC) ? (imm_en_q ? imm_q : rf_rdata_b) : alu_b_q;
  assign alu_op       = op_q;
  assign alu_carry_in = flags_q[2];

  assign rf_we    = (state_q == S_WB) && (op_q != NOWB_OP) && !illegal_w;
  assign rf_waddr = rd_q;
  assign rf_wdata = wdata_q;

  assign flag_c = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_n = flags_q[0];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed bench for alu_sequencer with a
// register-file and ALU environment plus an architectural reference model.
module tb_alu_sequencer;
  localparam int RA_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [7:0]      req_op = '0;
  logic [RA_W-1:0] req_rd = '0, req_ra = '0, req_rb = '0;
  logic            req_imm_en = 1'b0;
  logic [31:0]     req_imm = '0;
  logic            req_setflags = 1'b0;
  logic [RA_W-1:0] rf_raddr_a, rf_raddr_b;
  logic [31:0]     rf_rdata_a = '0, rf_rdata_b = '0;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [31:0]     rf_wdata;
  logic [31:0]     alu_a, alu_b, alu_c;
  logic [7:0]      alu_op;
  logic            alu_carry_in, alu_carry_out, alu_is_zero, alu_is_negative;
  logic            flag_c, flag_z, flag_n, busy;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic            illegal_op;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf_mem [16];
  logic [31:0] ref_rf [16];
  logic        ref_c = 1'b0, ref_z = 1'b0, ref_n = 1'b0;

  alu_sequencer #(.RA_W(RA_W), .NOWB_OP(8'd8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
    .req_imm_en(req_imm_en), .req_imm(req_imm), .req_setflags(req_setflags),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
    .alu_c(alu_c), .alu_carry_out(alu_carry_out),
    .alu_is_zero(alu_is_zero), .alu_is_negative(alu_is_negative),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {carry_out, result}
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [7:0] op, input logic cin);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      8'd0:       return {1'b0, a} + {1'b0, b};
      8'd1:       return {1'b0, a} + {1'b0, b} + {32'd0, cin};
      8'd2, 8'd8: return {1'b0, a} + {1'b0, ~b} + 33'd1;
      8'd3:       return {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
      8'd4:       return {1'b0, a & b};
      8'd5:       return {1'b0, a | b};
      8'd6:       return {1'b0, a ^ b};
      8'd7:       return {1'b0, a << sh};
      8'd12:      return {1'b0, a >> sh};
      8'd13:      return {1'b0, 32'($signed(a) >>> sh)};
      8'd16:      return {1'b0, a * b};
      default:    return 33'd0;
    endcase
  endfunction

  function automatic bit op_legal(input logic [7:0] op);
    return (op <= 8'd8) || (op == 8'd12) || (op == 8'd13) || (op == 8'd16);
  endfunction

  logic [32:0] alu_res;
  assign alu_res         = alu_fn(alu_a, alu_b, alu_op, alu_carry_in);
  assign alu_c           = alu_res[31:0];
  assign alu_carry_out   = alu_res[32];
  assign alu_is_zero     = (alu_res[31:0] == 32'd0);
  assign alu_is_negative = alu_res[31];

  // Register file environment: synchronous read, write-first
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata_a <= (rf_we && rf_waddr == rf_raddr_a) ? rf_wdata : rf_mem[rf_raddr_a];
    rf_rdata_b <= (rf_we && rf_waddr == rf_raddr_b) ? rf_wdata : rf_mem[rf_raddr_b];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [31:0] v);
    rf_mem[r] = v;
    ref_rf[r] = v;
  endtask

  task automatic check_flags(input string tag);
    check_val(tag, {29'd0, flag_c, flag_z, flag_n}, {29'd0, ref_c, ref_z, ref_n});
  endtask

  // Issue one instruction starting in IDLE or WB; returns in WB when b2b_next
  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic imm_en, input logic [31:0] imm,
                       input logic setf, input bit b2b_next);
    logic [31:0] ea, eb;
    logic [32:0] r;
    bit ill, ewe;
    req_op = op; req_rd = rd; req_ra = ra; req_rb = rb;
    req_imm_en = imm_en; req_imm = imm; req_setflags = setf; req_valid = 1'b1;
    check_val("ready_offer", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("busy_read", 32'(busy), 32'd1);
    check_val("we_read", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    ea = ref_rf[ra];
    eb = imm_en ? imm : ref_rf[rb];
    check_val("alu_a", alu_a, ea);
    check_val("alu_b", alu_b, eb);
    check_val("alu_op", 32'(alu_op), 32'(op));
    check_val("carry_in", 32'(alu_carry_in), 32'(ref_c));
    check_val("we_exec", 32'(rf_we), 32'd0);
    r = alu_fn(ea, eb, op, ref_c);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ill = !op_legal(op);
`else
    ill = 1'b0;
`endif
    ewe = (op != 8'd8) && !ill;
    if (setf && !ill) begin
      ref_c = r[32];
      ref_z = (r[31:0] == 32'd0);
      ref_n = r[31];
    end
    @(posedge clk); #1;
    check_val("we_wb", 32'(rf_we), 32'(ewe));
    if (ewe) begin
      check_val("waddr", 32'(rf_waddr), 32'(rd));
      check_val("wdata", rf_wdata, r[31:0]);
      ref_rf[rd] = r[31:0];
    end
    check_flags("flags_wb");
    check_val("ready_wb", 32'(req_ready), 32'd1);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    check_val("illegal_op", 32'(illegal_op), 32'(ill));
`endif
    if (!b2b_next) begin
      @(posedge clk); #1;
      check_val("busy_idle", 32'(busy), 32'd0);
      check_val("we_idle", 32'(rf_we), 32'd0);
    end
  endtask

  // Issue an instruction and hit reset during EXEC (in_wb=0) or WB (in_wb=1)
  task automatic issue_abort(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] ra,
                             input logic [3:0] rb, input bit in_wb);
    req_op = op; req_rd = rd; req_ra = ra; req_rb = rb;
    req_imm_en = 1'b0; req_imm = '0; req_setflags = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    if (in_wb) begin
      @(posedge clk); #1;
    end
    #1 reset = 1'b1;
    #1;
    ref_c = 1'b0; ref_z = 1'b0; ref_n = 1'b0;
    check_val("abort_we", 32'(rf_we), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_ready", 32'(req_ready), 32'd1);
    check_flags("abort_flags");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("post_abort_we", 32'(rf_we), 32'd0);
      check_flags("post_abort_flags");
    end
    check_val("abort_rd_kept", rf_mem[rd], ref_rf[rd]);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] legal_ops [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                 8'd8, 8'd12, 8'd13, 8'd16};

  initial begin
    logic [7:0] op;
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

    // Asynchronous reset, no clock edge yet
    #1 reset = 1'b1;
    #1;
    check_val("rst_we", 32'(rf_we), 32'd0);
    check_flags("rst_flags");
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_raddr_a", 32'(rf_raddr_a), 32'd0);
    check_val("rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Simple add with flags
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    issue(8'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("t2_r3", rf_mem[3], 32'd12);

    // Carry/zero via immediate, then adc consumes carry
    set_reg(4'd1, 32'hFFFF_FFFF);
    set_reg(4'd2, 32'd1);
    issue(8'd0, 4'd5, 4'd1, 4'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    check_val("t3_flags", {29'd0, flag_c, flag_z, flag_n}, 32'b110);
    issue(8'd1, 4'd6, 4'd2, 4'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    check_val("t3_r6", rf_mem[6], 32'd3);

    // Compare: no write, N set; then equal values set Z
    set_reg(4'd1, 32'd3);
    set_reg(4'd2, 32'd5);
    set_reg(4'd7, 32'hA5A5_0000);
    issue(8'd8, 4'd7, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("t4_flags_lt", {29'd0, flag_c, flag_z, flag_n}, 32'b001);
    check_val("t4_r7_kept", rf_mem[7], 32'hA5A5_0000);
    issue(8'd8, 4'd7, 4'd1, 4'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("t4_flags_eq", {29'd0, flag_c, flag_z, flag_n}, 32'b110);

    // Back-to-back with RAW hazard through r3
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    issue(8'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0, 1'b1);
    issue(8'd0, 4'd4, 4'd3, 4'd3, 1'b0, 32'd0, 1'b0, 1'b0);
    check_val("t5_r4", rf_mem[4], 32'd24);

    // Reset during EXEC, then during WB, with flags nonzero beforehand
    issue(8'd2, 4'd8, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    issue_abort(8'd0, 4'd9, 4'd1, 4'd2, 1'b0);
    issue(8'd2, 4'd8, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    issue_abort(8'd0, 4'd10, 4'd1, 4'd2, 1'b1);

    // Undefined op (trapped when the feature is built in, else writes 0)
    issue(8'd2, 4'd8, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(8'd9, 4'd11, 4'd1, 4'd2, 1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized stream, random back-to-back
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(9, 20));
      else op = legal_ops[$urandom_range(0, 11)];
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom,
            1'($urandom), (i < 59) && ($urandom_range(0, 1) == 1));
    end

    for (int i = 0; i < 16; i++) check_val("final_rf", rf_mem[i], ref_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
